// File: rtl/ps2_key_encoder.sv
// Queued key-command encoder producing the 11-bit ps2_key event bus
// with enforced spacing between events and optional press/release taps.
module ps2_key_encoder #(
   parameter int DEPTH = 8,
   parameter int GAP   = 16,
   parameter int HOLD  = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_code,
   input  logic        in_ext,
   input  logic [1:0]  in_mode,
   output logic [10:0] ps2_key,
   output logic        busy
);

   localparam int AW   = $clog2(DEPTH);
   localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
   localparam int CW   = $clog2(MAXC);

   typedef enum logic [1:0] {
      IDLE,
      TAPHOLD,
      WAIT
   } state_t;

   logic [10:0]   mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          take;
   logic [10:0]   head;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [10:0]   key_n;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = ~full & ~flush;
   assign push     = in_valid & in_ready;
   assign head     = mem[rd_ptr[AW-1:0]];
   assign busy     = (state != IDLE) | ~empty;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= {in_mode, in_ext, in_code};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         ps2_key <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ps2_key <= key_n;
      end
   end

   // The last WAIT cycle doubles as an IDLE slot so queued events
   // come out exactly GAP cycles apart.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      key_n   = ps2_key;
      pop     = 1'b0;
      take    = 1'b0;
      unique case (state)
         IDLE: take = 1'b1;
         TAPHOLD: begin
            if (cnt == '0) begin
               key_n   = {~ps2_key[10], 1'b0, ps2_key[8:0]};
               cnt_n   = CW'(GAP - 1);
               state_n = WAIT;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_n = IDLE;
               take    = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if (take && !empty && !flush) begin
         pop = 1'b1;
         unique case (head[10:9])
            2'b00: begin
               key_n   = {~ps2_key[10], 1'b1, head[8:0]};
               cnt_n   = CW'(GAP - 1);
               state_n = WAIT;
            end
            2'b01: begin
               key_n   = {~ps2_key[10], 1'b0, head[8:0]};
               cnt_n   = CW'(GAP - 1);
               state_n = WAIT;
            end
            2'b10: begin
               key_n   = {~ps2_key[10], 1'b1, head[8:0]};
               cnt_n   = CW'(HOLD - 1);
               state_n = TAPHOLD;
            end
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Randomized and directed bench for ps2_key_encoder, checked against
// an event-schedule model of emission times and values.
module tb_ps2_key_encoder;

   localparam int DEPTH = 8;
   localparam int GAP   = 16;
   localparam int HOLD  = 1024;

   logic        clk = 0;
   logic        reset = 1;
   logic        flush = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [7:0]  in_code = 0;
   logic        in_ext = 0;
   logic [1:0]  in_mode = 0;
   logic [10:0] ps2_key;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   ps2_key_encoder #(.DEPTH(DEPTH), .GAP(GAP), .HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_ext(in_ext), .in_mode(in_mode),
      .ps2_key(ps2_key), .busy(busy)
   );

   always #5 clk = ~clk;

   int ecnt;
   always @(posedge clk or posedge reset)
      if (reset) ecnt <= 0;
      else       ecnt <= ecnt + 1;

   // model: each command is emitted at max(accept+1, next free slot)
   int          exp_t[$];
   logic [10:0] exp_k[$];
   int          ready_at = 0;
   logic        tog = 0;
   int          last_t = 0;

   task automatic model_push(input logic [1:0] m, input logic e,
                             input logic [7:0] c, input int acc);
      int t;
      t = (acc + 1 > ready_at) ? acc + 1 : ready_at;
      last_t = t;
      case (m)
         2'd0, 2'd1: begin
            tog = ~tog;
            exp_t.push_back(t);
            exp_k.push_back({tog, (m == 2'd0), e, c});
            ready_at = t + GAP;
         end
         2'd2: begin
            tog = ~tog;
            exp_t.push_back(t);
            exp_k.push_back({tog, 1'b1, e, c});
            tog = ~tog;
            exp_t.push_back(t + HOLD);
            exp_k.push_back({tog, 1'b0, e, c});
            ready_at = t + HOLD + GAP;
         end
         default: ready_at = t + 1;
      endcase
   endtask

   // live monitor: every toggle must match the next scheduled event
   logic        last_tog = 0;
   logic [10:0] last_key = 0;
   int          mon_t;
   logic [10:0] mon_k;
   int          obs_t[$];
   logic [10:0] obs_k[$];

   always @(negedge clk) begin
      if (!reset) begin
         if (ps2_key[10] !== last_tog) begin
            obs_t.push_back(ecnt);
            obs_k.push_back(ps2_key);
            n_tests++;
            if (exp_t.size() == 0) begin
               n_fail++;
               $display("FAIL event: unexpected ps2_key=%h at edge %0d",
                        ps2_key, ecnt);
            end else begin
               mon_t = exp_t.pop_front();
               mon_k = exp_k.pop_front();
               if (ecnt !== mon_t || ps2_key !== mon_k) begin
                  n_fail++;
                  $display("FAIL event: got %h at edge %0d, want %h at edge %0d",
                           ps2_key, ecnt, mon_k, mon_t);
               end
            end
         end else begin
            n_tests++;
            if (ps2_key !== last_key) begin
               n_fail++;
               $display("FAIL hold: ps2_key %h changed to %h without toggle at edge %0d",
                        last_key, ps2_key, ecnt);
            end
         end
      end
      last_tog = ps2_key[10];
      last_key = ps2_key;
   end

   // called right after a negedge; offers one command for one cycle
   task automatic offer(input logic [1:0] m, input logic e,
                        input logic [7:0] c, input bit mdl, output bit ok);
      int acc;
      in_valid = 1; in_mode = m; in_ext = e; in_code = c;
      #1;
      ok  = in_ready;
      acc = ecnt + 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      if (ok && mdl) model_push(m, e, c, acc);
   endtask

   task automatic push(input logic [1:0] m, input logic e, input logic [7:0] c);
      bit ok;
      ok = 0;
      for (int i = 0; i < 4000 && !ok; i++) offer(m, e, c, 1, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL push: in_ready stuck at %b, want 1", in_ready);
      end
   endtask

   task automatic wait_idle(input int lim, output bit done);
      done = 0;
      for (int i = 0; i < lim; i++) begin
         if (busy === 1'b0) begin
            done = 1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_tests++;
      if (ps2_key !== 11'h000) begin
         n_fail++; $display("FAIL reset_key: got %h want 000", ps2_key);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready);
      end
      flush = 1;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready);
      end
      flush = 0;
      #1;
      reset = 0;
   endtask

   task automatic test_basic;
      bit ok;
      for (int i = 0; i < 50 && ecnt < 9; i++) @(negedge clk);
      offer(2'd0, 1'b0, 8'h1C, 1, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL basic_accept: got %b want 1", ok);
      end
      @(negedge clk);
      n_tests++;
      if (ps2_key !== {1'b1, 1'b1, 1'b0, 8'h1C}) begin
         n_fail++;
         $display("FAIL basic_key: got %h at edge %0d want %h at edge 11",
                  ps2_key, ecnt, {1'b1, 1'b1, 1'b0, 8'h1C});
      end
      while (ecnt < 10 + GAP) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy_hi: got %b want 1", busy);
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy_lo: got %b want 0 at edge %0d",
                            busy, ecnt);
      end
   endtask

   task automatic test_back_to_back;
      bit ok;
      obs_t.delete(); obs_k.delete();
      offer(2'd0, 1'b1, 8'h75, 1, ok);
      offer(2'd1, 1'b1, 8'h75, 1, ok);
      wait_idle(4 * GAP, ok);
      repeat (4) @(negedge clk);
      n_tests++;
      if (!ok || obs_t.size() != 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d toggles idle=%b, want 2", obs_t.size(), ok);
      end else begin
         n_tests++;
         if (obs_t[1] - obs_t[0] != GAP) begin
            n_fail++; $display("FAIL b2b_gap: got %0d want %0d",
                               obs_t[1] - obs_t[0], GAP);
         end
         n_tests++;
         if (obs_k[1][9:8] !== 2'b01 || obs_k[0][9:8] !== 2'b11) begin
            n_fail++; $display("FAIL b2b_flags: got %b/%b want 11/01",
                               obs_k[0][9:8], obs_k[1][9:8]);
         end
      end
   endtask

   task automatic test_tap;
      bit ok;
      obs_t.delete(); obs_k.delete();
      offer(2'd2, 1'b0, 8'h29, 1, ok);
      offer(2'd0, 1'b0, 8'h11, 1, ok);
      wait_idle(HOLD + 4 * GAP, ok);
      repeat (4) @(negedge clk);
      n_tests++;
      if (!ok || obs_t.size() != 3) begin
         n_fail++;
         $display("FAIL tap_count: got %0d toggles idle=%b, want 3", obs_t.size(), ok);
      end else begin
         n_tests++;
         if (obs_t[1] - obs_t[0] != HOLD) begin
            n_fail++; $display("FAIL tap_hold: got %0d want %0d",
                               obs_t[1] - obs_t[0], HOLD);
         end
         n_tests++;
         if (obs_k[1][9:0] !== {2'b00, 8'h29}) begin
            n_fail++; $display("FAIL tap_release: got %h want %h",
                               obs_k[1][9:0], {2'b00, 8'h29});
         end
         n_tests++;
         if (obs_t[2] - obs_t[1] != GAP) begin
            n_fail++; $display("FAIL tap_next: got %0d want %0d",
                               obs_t[2] - obs_t[1], GAP);
         end
      end
   endtask

   task automatic test_fill;
      bit ok;
      int acc_n;
      int p;
      acc_n = 0;
      p = 0;
      obs_t.delete(); obs_k.delete();
      offer(2'd2, 1'b1, 8'h4A, 1, ok);
      @(negedge clk);
      for (int i = 0; i < DEPTH + 3; i++) begin
         offer({1'b0, i[0]}, i[1], 8'h10 + 8'(i), 1, ok);
         if (ok) begin
            if (acc_n == 0) p = last_t;
            acc_n++;
         end
      end
      n_tests++;
      if (acc_n != DEPTH) begin
         n_fail++; $display("FAIL fill_accepts: got %0d want %0d", acc_n, DEPTH);
      end
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL fill_ready: got %b want 0", in_ready);
      end
      ok = 0;
      for (int i = 0; i < HOLD + (DEPTH + 4) * GAP; i++) begin
         @(negedge clk);
         if (ecnt == p - 1) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
               n_fail++; $display("FAIL fill_ready_pre: got %b want 0", in_ready);
            end
         end
         if (ecnt == p) begin
            n_tests++;
            if (in_ready !== 1'b1) begin
               n_fail++; $display("FAIL fill_ready_post: got %b want 1", in_ready);
            end
         end
         if (busy === 1'b0) begin
            ok = 1;
            break;
         end
      end
      repeat (4) @(negedge clk);
      n_tests++;
      if (!ok || exp_t.size() != 0 || obs_t.size() != DEPTH + 2) begin
         n_fail++;
         $display("FAIL fill_drain: idle=%b pending=%0d toggles=%0d, want 1/0/%0d",
                  ok, exp_t.size(), obs_t.size(), DEPTH + 2);
      end
   endtask

   task automatic test_flush;
      bit ok;
      int tt;
      obs_t.delete(); obs_k.delete();
      offer(2'd2, 1'b0, 8'h29, 1, ok);
      tt = last_t;
      for (int i = 0; i < 4; i++) offer(2'd0, 1'b0, 8'h60 + 8'(i), 0, ok);
      flush = 1;
      in_valid = 1; in_mode = 2'd0; in_code = 8'h77; in_ext = 0;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL flush_block: got %b want 0", in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      flush = 0;
      in_valid = 0;
      for (int i = 0; i < HOLD + 4 * GAP && ecnt < tt + HOLD + 2 * GAP; i++) begin
         @(negedge clk);
         if (ecnt == tt + HOLD + GAP - 1) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++; $display("FAIL flush_busy_hi: got %b want 1", busy);
            end
         end
         if (ecnt == tt + HOLD + GAP) begin
            n_tests++;
            if (busy !== 1'b0) begin
               n_fail++; $display("FAIL flush_busy_lo: got %b want 0", busy);
            end
         end
      end
      n_tests++;
      if (obs_t.size() != 2 || exp_t.size() != 0) begin
         n_fail++;
         $display("FAIL flush_events: got %0d toggles %0d pending, want 2/0",
                  obs_t.size(), exp_t.size());
      end else begin
         n_tests++;
         if (obs_t[1] - obs_t[0] != HOLD || obs_k[1][9] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_release: got dt=%0d press=%b want %0d/0",
                     obs_t[1] - obs_t[0], obs_k[1][9], HOLD);
         end
      end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int t0;
      offer(2'd0, 1'b0, 8'h33, 1, ok);
      if (tog == 1'b0) offer(2'd0, 1'b0, 8'h34, 1, ok);
      t0 = last_t;
      for (int i = 0; i < 4 * GAP && ecnt < t0 + 4; i++) @(negedge clk);
      n_tests++;
      if (ps2_key[10] !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL rmid_pre: got tog=%b busy=%b want 1/1",
                            ps2_key[10], busy);
      end
      #2;
      reset = 1;
      #1;
      n_tests++;
      if (ps2_key !== 11'h000 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rmid_async: got key=%h busy=%b want 000/0",
                            ps2_key, busy);
      end
      @(negedge clk);
      #2;
      reset = 0;
      ready_at = 0;
      tog = 0;
      n_tests++;
      if (exp_t.size() != 0) begin
         n_fail++; $display("FAIL rmid_pending: got %0d want 0", exp_t.size());
      end
      @(negedge clk);
      offer(2'd0, 1'b1, 8'h5A, 1, ok);
      @(negedge clk);
      n_tests++;
      if (!ok || ps2_key !== {1'b1, 1'b1, 1'b1, 8'h5A}) begin
         n_fail++; $display("FAIL rmid_after: got %h accepted=%b want %h",
                            ps2_key, ok, {1'b1, 1'b1, 1'b1, 8'h5A});
      end
      wait_idle(4 * GAP, ok);
   endtask

   task automatic test_random;
      bit ok;
      int r;
      logic [1:0] m;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(5, 25)) @(negedge clk);
         else
            repeat ($urandom_range(0, 1)) @(negedge clk);
         r = $urandom_range(0, 19);
         m = (r < 2) ? 2'd2 : (r < 4) ? 2'd3 : {1'b0, r[0]};
         push(m, 1'($urandom), 8'($urandom));
      end
      wait_idle(50 * (HOLD + GAP), ok);
      repeat (GAP) @(negedge clk);
      n_tests++;
      if (!ok || exp_t.size() != 0) begin
         n_fail++; $display("FAIL random_drain: idle=%b pending=%0d want 1/0",
                            ok, exp_t.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_tap();
      test_fill();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
